spi_fsm: RTL and testbench

//   Transaction controller for the SPI memory datapath. Consumes conditioned CS and SCLK edge

---
 rtl/spi_fsm_if.sv | 24 ++
 rtl/spi_fsm.sv | 106 ++++++++++
 tb/tb_spi_fsm.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_fsm_if.sv
// Purpose: bundles the SPI transaction controller's strobe inputs and control outputs.
// Signals: cs_n, sclk_rise, sclk_fall, rw_bit (towards controller);
//          addr_we, dm_we, sr_we, miso_buff_en (from controller).
// master = side producing strobes (conditioner/shift register); slave = controller.
interface spi_fsm_if;
  logic cs_n;          // conditioned chip select, active low
  logic sclk_rise;     // one-cycle strobe, SCLK rising edge
  logic sclk_fall;     // one-cycle strobe, SCLK falling edge
  logic rw_bit;        // shift register parallelOut[0]
  logic addr_we;       // latch parallelOut as memory address
  logic dm_we;         // data memory write enable
  logic sr_we;         // shift register parallel load
  logic miso_buff_en;  // drive MISO from shift register serialOut

  modport master (
    output cs_n, sclk_rise, sclk_fall, rw_bit,
    input  addr_we, dm_we, sr_we, miso_buff_en
  );

  modport slave (
    input  cs_n, sclk_rise, sclk_fall, rw_bit,
    output addr_we, dm_we, sr_we, miso_buff_en
  );
endinterface

// File: rtl/spi_fsm.sv
// Purpose: SPI memory transaction controller; frame = ADDR_BITS address bits + R/W bit on
//          SCLK rises, then DATA_BITS data bits (rises for write, falls for read).
// Ports: clk, reset (sync, active high), bus (spi_fsm_if.slave). Outputs are registered (Moore);
//        each control pulse appears the cycle after the edge strobe that completes its phase.
module spi_fsm #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  spi_fsm_if.slave   bus
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    GET_ADDR   = 4'd1,
    LATCH_ADDR = 4'd2,
    READ_LOAD  = 4'd3,
    READ_SEND  = 4'd4,
    WRITE_GET  = 4'd5,
    WRITE_MEM  = 4'd6,
    DONE       = 4'd7
  } state_t;

  // Address phase ends on rise number ADDR_BITS+1 (address plus R/W bit), i.e. when the
  // pre-increment count equals ADDR_BITS.
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             addr_we_q, dm_we_q, sr_we_q, miso_en_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (bus.cs_n) begin
      // Deselect aborts any frame; partial data is simply dropped.
      state_d = IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Strobes in the select cycle are ignored.
          state_d = GET_ADDR;
          count_d = '0;
        end
        GET_ADDR: begin
          if (bus.sclk_rise) begin
            count_d = count_q + 1'b1;
            if (count_q == ADDR_LAST) state_d = LATCH_ADDR;
          end
        end
        LATCH_ADDR: begin
          count_d = '0;
          state_d = bus.rw_bit ? READ_LOAD : WRITE_GET;
        end
        READ_LOAD: state_d = READ_SEND;
        READ_SEND: begin
          if (bus.sclk_fall) begin
            count_d = count_q + 1'b1;
            if (count_q == DATA_LAST) state_d = DONE;
          end
        end
        WRITE_GET: begin
          if (bus.sclk_rise) begin
            count_d = count_q + 1'b1;
            if (count_q == DATA_LAST) state_d = WRITE_MEM;
          end
        end
        WRITE_MEM: state_d = DONE;
        DONE:      state_d = DONE;
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      addr_we_q <= 1'b0;
      dm_we_q   <= 1'b0;
      sr_we_q   <= 1'b0;
      miso_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      addr_we_q <= (state_d == LATCH_ADDR);
      dm_we_q   <= (state_d == WRITE_MEM);
      sr_we_q   <= (state_d == READ_LOAD);
      miso_en_q <= (state_d == READ_SEND);
    end
  end

  assign bus.addr_we      = addr_we_q;
  assign bus.dm_we        = dm_we_q;
  assign bus.sr_we        = sr_we_q;
  assign bus.miso_buff_en = miso_en_q;

endmodule

// File: tb/tb_spi_fsm.sv
module tb_spi_fsm;
  localparam int AB = 7;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic reset;
  spi_fsm_if bus ();

  spi_fsm #(.ADDR_BITS(AB), .DATA_BITS(DB), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: counts qualified edges in the current selection and derives
  // the expected control pulses from their ordinal numbers.
  bit e_addr, e_dm, e_sr, e_miso;
  bit n_a, n_d, n_s, n_m;
  bit m_on, m_done, m_rw;
  int m_rise, m_fall;
  // Tallies for literal latency checks.
  int n_addr = 0, n_dm = 0, n_sr = 0, n_miso = 0;
  int addr_cyc = -1, dm_cyc = -1, sr_cyc = -1, miso_first = -1, miso_last = -1;
  bit prev_miso = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset || bus.cs_n) begin
      m_on = 0; m_done = 0; m_rise = 0; m_fall = 0;
      e_addr = 0; e_dm = 0; e_sr = 0; e_miso = 0;
    end else if (!m_on) begin
      m_on = 1;   // select cycle: edges here do not count
    end else begin
      n_a = 0; n_d = 0; n_s = 0; n_m = 0;
      if (e_addr) begin
        m_rw = bus.rw_bit;
        n_s  = m_rw;
      end else if (e_sr) begin
        n_m = 1; m_fall = 0;
      end else if (e_miso) begin
        if (bus.sclk_fall) m_fall++;
        if (m_fall == DB) m_done = 1;
        else n_m = 1;
      end else if (e_dm) begin
        m_done = 1;
      end else if (!m_done && bus.sclk_rise) begin
        m_rise++;
        if (m_rise == AB + 1) n_a = 1;
        else if (m_rise == AB + 1 + DB) n_d = 1;
      end
      e_addr = n_a; e_dm = n_d; e_sr = n_s; e_miso = n_m;
    end
    #1;
    chk("addr_we", int'(bus.addr_we), int'(e_addr));
    chk("dm_we", int'(bus.dm_we), int'(e_dm));
    chk("sr_we", int'(bus.sr_we), int'(e_sr));
    chk("miso_buff_en", int'(bus.miso_buff_en), int'(e_miso));
    if (bus.addr_we === 1'b1) begin n_addr++; addr_cyc = cyc; end
    if (bus.dm_we === 1'b1) begin n_dm++; dm_cyc = cyc; end
    if (bus.sr_we === 1'b1) begin n_sr++; sr_cyc = cyc; end
    if (bus.miso_buff_en === 1'b1) begin
      n_miso++; miso_last = cyc;
      if (!prev_miso) miso_first = cyc;
    end
    prev_miso = (bus.miso_buff_en === 1'b1);
  end

  int b_addr, b_dm, b_sr, b_miso;
  task automatic snap();
    b_addr = n_addr; b_dm = n_dm; b_sr = n_sr; b_miso = n_miso;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs(input bit v);
    @(negedge clk); bus.cs_n = v;
  endtask

  // Sends the top n bits of v MSB first, one rise strobe per bit; rc = cycle of last strobe.
  task automatic rises(input logic [7:0] v, input int n, output int rc);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk); bus.sclk_rise = 1'b1; bus.rw_bit = v[i]; rc = cyc;
      @(negedge clk); bus.sclk_rise = 1'b0;
    end
  endtask

  task automatic falls(input int n, output int rc);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); bus.sclk_fall = 1'b1; rc = cyc;
      @(negedge clk); bus.sclk_fall = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int rc1, rc2, rc3, lf, dummy;

  initial begin
    reset = 1'b1;
    bus.cs_n = 1'b1; bus.sclk_rise = 1'b0; bus.sclk_fall = 1'b0; bus.rw_bit = 1'b0;
    idle(3);
    chk("rst_addr_we", int'(bus.addr_we), 0);
    chk("rst_dm_we", int'(bus.dm_we), 0);
    chk("rst_sr_we", int'(bus.sr_we), 0);
    chk("rst_miso", int'(bus.miso_buff_en), 0);
    reset = 1'b0;
    idle(2);

    // Write frame: 0x54 (addr 0x2A, rw=0), data 0xA5.
    snap(); cs(0);
    rises(8'h54, 8, rc1);
    rises(8'hA5, 8, rc2);
    idle(3);
    chk("wr_addr_cnt", n_addr - b_addr, 1);
    chk("wr_addr_lat", addr_cyc, rc1 + 1);
    chk("wr_dm_cnt", n_dm - b_dm, 1);
    chk("wr_dm_lat", dm_cyc, rc2 + 1);
    chk("wr_sr_cnt", n_sr - b_sr, 0);
    chk("wr_miso_cnt", n_miso - b_miso, 0);
    cs(1); idle(2);

    // Read frame: 0x55 (addr 0x2A, rw=1); one cycle carries both strobes.
    snap(); cs(0);
    rises(8'h55, 8, rc1);
    idle(3);
    falls(3, lf);
    @(negedge clk); bus.sclk_rise = 1'b1; bus.sclk_fall = 1'b1;
    @(negedge clk); bus.sclk_rise = 1'b0; bus.sclk_fall = 1'b0;
    falls(4, lf);
    idle(3);
    chk("rd_addr_lat", addr_cyc, rc1 + 1);
    chk("rd_sr_cnt", n_sr - b_sr, 1);
    chk("rd_sr_lat", sr_cyc, rc1 + 2);
    chk("rd_dm_cnt", n_dm - b_dm, 0);
    chk("rd_miso_first", miso_first, rc1 + 3);
    chk("rd_miso_last", miso_last, lf);
    chk("rd_miso_cnt", n_miso - b_miso, lf - (rc1 + 3) + 1);
    // Extra edges while done.
    snap();
    rises(8'hFF, 8, dummy);
    falls(4, dummy);
    chk("done_extra_addr", n_addr - b_addr, 0);
    chk("done_extra_miso", n_miso - b_miso, 0);
    cs(1); idle(2);

    // Abort in address after 5 rises, then a fresh frame counts from zero.
    snap(); cs(0);
    rises(8'hF0, 5, dummy);
    cs(1); idle(2);
    chk("abort_addr_cnt", n_addr - b_addr, 0);
    snap(); cs(0);
    rises(8'h54, 8, rc1);
    rises(8'hFF, 7, dummy);
    cs(1); idle(3);
    chk("abort_wr_addr_lat", addr_cyc, rc1 + 1);
    chk("abort_wr_dm_cnt", n_dm - b_dm, 0);

    // Reset in the middle of a read after 3 falls.
    snap(); cs(0);
    rises(8'h55, 8, rc1);
    idle(3);
    falls(3, dummy);
    @(negedge clk);
    chk("pre_rst_miso", int'(bus.miso_buff_en), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_miso", int'(bus.miso_buff_en), 0);
    chk("mid_rst_sr", int'(bus.sr_we), 0);
    chk("mid_rst_addr", int'(bus.addr_we), 0);
    reset = 1'b0; bus.cs_n = 1'b1;
    idle(2);

    // Back-to-back write then read with a single cs_n-high cycle; the read's select
    // cycle also carries a rise strobe that must be ignored.
    snap(); cs(0);
    rises(8'h54, 8, rc1);
    rises(8'h3C, 8, rc2);
    idle(2);
    rises(8'hFF, 3, dummy);
    cs(1);
    @(negedge clk); bus.cs_n = 1'b0; bus.sclk_rise = 1'b1;
    @(negedge clk); bus.sclk_rise = 1'b0;
    rises(8'h55, 8, rc3);
    idle(3);
    falls(8, lf);
    falls(2, dummy);
    cs(1); idle(3);
    chk("b2b_addr_cnt", n_addr - b_addr, 2);
    chk("b2b_addr_lat", addr_cyc, rc3 + 1);
    chk("b2b_dm_cnt", n_dm - b_dm, 1);
    chk("b2b_dm_lat", dm_cyc, rc2 + 1);
    chk("b2b_sr_lat", sr_cyc, rc3 + 2);
    chk("b2b_miso_last", miso_last, lf);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
